// File: rtl/sbox_slot_scheduler.sv
// sbox_slot_scheduler
//   Time-shares one external 4-lane (32-bit) combinational S-box between the
//   round datapath (128-bit SubBytes, issued as 4 words MSW-first) and the key
//   expansion (32-bit SubWord). One slot per clock. Each requester has a
//   one-job buffer. Results are returned registered as a one-cycle pulse.
//
//   Optional feature (macro SBOX_SCHED_ROTWORD_EN): the key word is rotated
//   left by 8 bits (AES RotWord) before it is issued, so
//   key_word_out = SubWord(RotWord(key_word_in)). The state path is unchanged.
//
//   Parameters
//     KEY_PRIORITY  1: key job wins every contended slot
//                   0: round-robin on contention; the requester that did not
//                      get the previous slot wins
//   Ports
//     clk, rst_n                        clock (rising edge), async active-low reset
//     state_req_valid/ready, state_in   128-bit SubBytes job handshake
//     state_resp_valid, state_out       one-cycle result pulse + substituted state
//     key_req_valid/ready, key_word_in  SubWord job handshake
//     key_resp_valid, key_word_out      one-cycle result pulse + substituted word
//     sbox_request / sbox_response      shared S-box input / output (same cycle)
//     busy                              any job buffered, in flight or responding
module sbox_slot_scheduler #(
  parameter bit KEY_PRIORITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         state_req_valid,
  output logic         state_req_ready,
  input  logic [127:0] state_in,
  output logic         state_resp_valid,
  output logic [127:0] state_out,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_word_in,
  output logic         key_resp_valid,
  output logic [31:0]  key_word_out,
  output logic [31:0]  sbox_request,
  input  logic [31:0]  sbox_response,
  output logic         busy
);

  localparam int NUM_WORDS = 4;

  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3, S_DONE} st_e;

  // Packed so that element [3] is state_in[127:96], i.e. word 0 (MSW).
  st_e                        st_q,        st_d;
  logic [NUM_WORDS-1:0][31:0] st_buf_q,    st_buf_d;
  logic [NUM_WORDS-2:0][31:0] st_res_q,    st_res_d;   // words 0..2; word 3 goes straight out
  logic [127:0]               state_out_q, state_out_d;
  logic                       key_pend_q,  key_pend_d;
  logic [31:0]                key_buf_q,   key_buf_d;
  logic [31:0]                key_out_q,   key_out_d;
  logic                       key_vld_q,   key_vld_d;
  logic                       last_key_q,  last_key_d;  // previous slot went to key

  logic        st_pend;
  logic        gnt_key;
  logic        gnt_st;
  logic        st_acc;
  logic        key_acc;
  logic [31:0] st_word;
  logic [31:0] key_issue;

`ifdef SBOX_SCHED_ROTWORD_EN
  // RotWord applied on entry so the buffered word is exactly what gets issued.
  assign key_issue = {key_word_in[23:0], key_word_in[31:24]};
`else
  assign key_issue = key_word_in;
`endif

  // Handshake: state buffer frees up in the response cycle so a new job can
  // be taken back-to-back; key buffer frees up once its slot has been used.
  assign state_req_ready  = (st_q == S_IDLE) || (st_q == S_DONE);
  assign key_req_ready    = !key_pend_q;
  assign st_acc           = state_req_valid && state_req_ready;
  assign key_acc          = key_req_valid && key_req_ready;

  assign state_resp_valid = (st_q == S_DONE);
  assign state_out        = state_out_q;
  assign key_resp_valid   = key_vld_q;
  assign key_word_out     = key_out_q;
  assign busy             = (st_q != S_IDLE) || key_pend_q || key_vld_q;

  // Slot grant from registered state only; no *_valid input reaches sbox_request.
  always_comb begin
    st_pend = (st_q == S_W0) || (st_q == S_W1) || (st_q == S_W2) || (st_q == S_W3);
    if (st_pend && key_pend_q) gnt_key = KEY_PRIORITY ? 1'b1 : !last_key_q;
    else                       gnt_key = key_pend_q;
    gnt_st = st_pend && !gnt_key;
  end

  always_comb begin
    case (st_q)
      S_W0:    st_word = st_buf_q[3];
      S_W1:    st_word = st_buf_q[2];
      S_W2:    st_word = st_buf_q[1];
      S_W3:    st_word = st_buf_q[0];
      default: st_word = '0;
    endcase
  end

  always_comb begin
    if (gnt_key)     sbox_request = key_buf_q;
    else if (gnt_st) sbox_request = st_word;
    else             sbox_request = '0;
  end

  // Next-state logic
  always_comb begin
    st_d        = st_q;
    st_buf_d    = st_buf_q;
    st_res_d    = st_res_q;
    state_out_d = state_out_q;
    key_pend_d  = key_pend_q;
    key_buf_d   = key_buf_q;
    key_out_d   = key_out_q;
    key_vld_d   = gnt_key;
    last_key_d  = last_key_q;

    if (gnt_key || gnt_st) last_key_d = gnt_key;

    // Word states advance only on edges where the state job held the slot.
    case (st_q)
      S_IDLE: if (st_acc) st_d = S_W0;
      S_W0: if (gnt_st) begin st_res_d[2] = sbox_response; st_d = S_W1; end
      S_W1: if (gnt_st) begin st_res_d[1] = sbox_response; st_d = S_W2; end
      S_W2: if (gnt_st) begin st_res_d[0] = sbox_response; st_d = S_W3; end
      S_W3: if (gnt_st) begin
        state_out_d = {st_res_q[2], st_res_q[1], st_res_q[0], sbox_response};
        st_d        = S_DONE;
      end
      S_DONE:  st_d = st_acc ? S_W0 : S_IDLE;
      default: st_d = S_IDLE;
    endcase
    if (st_acc) st_buf_d = state_in;

    // Key job: pending flag cleared on its slot, result captured the same edge.
    if (gnt_key) begin
      key_pend_d = 1'b0;
      key_out_d  = sbox_response;
    end
    if (key_acc) begin
      key_pend_d = 1'b1;
      key_buf_d  = key_issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= S_IDLE;
      st_buf_q    <= '0;
      st_res_q    <= '0;
      state_out_q <= '0;
      key_pend_q  <= 1'b0;
      key_buf_q   <= '0;
      key_out_q   <= '0;
      key_vld_q   <= 1'b0;
      last_key_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      st_buf_q    <= st_buf_d;
      st_res_q    <= st_res_d;
      state_out_q <= state_out_d;
      key_pend_q  <= key_pend_d;
      key_buf_q   <= key_buf_d;
      key_out_q   <= key_out_d;
      key_vld_q   <= key_vld_d;
      last_key_q  <= last_key_d;
    end
  end

endmodule

// File: doc/sbox_slot_scheduler.md
Name: sbox_slot_scheduler

Overview:
- Shares one 32-bit, 4-lane combinational S-box instance between two requesters.
- Requester 1 is the round datapath: SubBytes on a 128-bit state, issued as 4 words.
- Requester 2 is the key expansion: SubWord on a single 32-bit word.
- The scheduler grants one S-box slot per clock, buffers one job per requester, sequences state words MSW-first and returns registered results.

Parameters:
- KEY_PRIORITY, 1, 1: key job wins every contended slot. 0: round-robin on contention; the requester not granted in the previous slot wins.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- state_req_valid  in  1  128-bit SubBytes job offered
- state_req_ready  out  1  state job buffer free
- state_in  in  128  state to substitute
- state_resp_valid  out  1  one-cycle pulse, state_out valid
- state_out  out  128  substituted state
- key_req_valid  in  1  SubWord job offered
- key_req_ready  out  1  key job buffer free
- key_word_in  in  32  word to substitute
- key_resp_valid  out  1  one-cycle pulse, key_word_out valid
- key_word_out  out  32  substituted word
- sbox_request  out  32  to shared S-box input
- sbox_response  in  32  from shared S-box output; combinational, same cycle
- busy  out  1  any job buffered or in flight

Behaviour:
- Reset (async assert, sync release) clears all registers.
  - Ready outputs go to 1.
  - Valid outputs, state_out, key_word_out, sbox_request and busy go to 0.
  - Buffered jobs and the word counter are dropped.
  - No response pulse is issued for a job dropped by reset.
- Accept rule: a job is accepted on a rising edge where valid && ready.
  - ready deasserts the cycle after acceptance.
  - ready reasserts in the cycle that job's resp_valid is high, so back-to-back acceptance is allowed in that cycle.
- State job FSM: S_IDLE -> S_W0 -> S_W1 -> S_W2 -> S_W3 -> S_DONE -> S_IDLE.
  - Word n is state_in[127-32n -: 32].
  - The FSM advances only on edges where the state job held the slot; otherwise it holds in the current word state.
  - S_DONE lasts one cycle: state_resp_valid=1, state_out is the 4 captured words in original order.
- Key job: a pending flag plus a 32-bit register.
  - On the edge where the key job holds the slot, sbox_response is captured into key_word_out.
  - key_resp_valid=1 for the following cycle.
- Slot grant: evaluated each cycle from registered state only.
  - Only one pending requester: it gets the slot.
  - Both pending: KEY_PRIORITY decides.
  - Neither pending: sbox_request=0.
- sbox_request is a mux of registered words only; no combinational path from any *_valid input to sbox_request.
- Latency, uncontended:
  - State: accepted at edge E, words issued in cycles E+1..E+4, state_resp_valid in cycle E+5.
  - Key: accepted at E, issued in E+1, key_resp_valid in E+2.
  - Each lost slot adds exactly 1 cycle to the losing job.
- State and key responses may pulse in the same cycle.
- Response pulses carry no backpressure; the consumer must sample them.
- busy = state FSM != S_IDLE, or key pending, or any resp_valid high.
- Reset mid-job: the job is discarded immediately. The first post-reset acceptance behaves as from power-up.

Optional Feature:
- Macro: SBOX_SCHED_ROTWORD_EN.
- Defined: the key word is rotated left by 8 bits before issue (AES RotWord), so key_word_out = SubWord(RotWord(key_word_in)). The state path is unaffected.
- Undefined: key_word_out = SubWord(key_word_in). No rotation logic is present.

Test Plan:
- State only, state_in=0x00112233_445566778899aabb_ccddeeff accepted at edge E:
  - sbox_request shows 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff in cycles E+1..E+4.
  - state_out=0x638293c3_1bfc33f5_c4eeacea_4bc12816 with a 1-cycle state_resp_valid at E+5.
- Key only, feature off, key_word_in=0x09cf4f3c -> key_word_out=0x018a84eb, key_resp_valid at E+2.
- Key only, SBOX_SCHED_ROTWORD_EN defined, key_word_in=0x09cf4f3c -> sbox_request=0xcf4f3c09, key_word_out=0x8a84eb01.
- KEY_PRIORITY=1, state accepted at E and key 0x00000000 accepted at E+1:
  - Key slot in E+2 with key_word_out=0x63636363 at E+3.
  - State words in E+1, E+3, E+4, E+5; state_resp_valid at E+6.
- KEY_PRIORITY=0, state and key accepted on the same edge E, key re-offered immediately after each key response: grants alternate (key, state, key, state, ...) whenever both are pending, and the state job completes in 4 granted slots.
- rst_n pulled low during S_W2 -> all outputs 0 and readies 1 asynchronously; no state_resp_valid pulse; a new job after release completes at E+5.
